// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size codes, FSM states
// and the sub-word lane merge used by read-modify-write stores.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    // Replace the addressed byte/half of old_word with the low bits of wdata;
    // any other size replaces the whole word.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  offset
    );
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load alignment: selects the addressed byte/half lane of a
// memory word and zero- or sign-extends it to 32 bits.
module load_align_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = word[{offset, 3'b000} +: 8];
        half_val = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_val[7]}}, byte_val};
            SZ_HALF: data = {{16{sign_ext & half_val[15]}}, half_val};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator with read-modify-write sub-word stores.
// Optional misalignment trap enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [31:0]       mem_data_i
);

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   lat_cnt;

    logic               cap_write;
    logic               cap_signed;
    logic [1:0]         cap_size;
    logic [1:0]         cap_offset;
    logic [31:0]        cap_wdata;

    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        resp_rdata;

    logic [1:0]         req_size_eff;
    logic               accept;
    logic               misaligned;
    logic               rd_done;
    logic [31:0]        load_data;
    logic [31:0]        merged_word;

    // The reserved size code behaves exactly like a word access.
    assign req_size_eff = (req_size_i == 2'b11) ? SZ_WORD : req_size_i;
    assign accept       = (state == IDLE) && req_valid_i;
    assign rd_done      = (state == RD) && (lat_cnt == '0);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic resp_err;

    assign misaligned = ((req_size_eff == SZ_HALF) && req_addr_i[0]) ||
                        ((req_size_eff == SZ_WORD) && (req_addr_i[1:0] != 2'b00));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            resp_err <= 1'b0;
        end else if (accept) begin
            resp_err <= misaligned;
        end
    end

    assign resp_err_o = (state == RESP) && resp_err;
`else
    assign misaligned = 1'b0;
    assign resp_err_o = 1'b0;
`endif

    load_align_ext u_load_align_ext (
        .word     (mem_data_i),
        .size     (cap_size),
        .offset   (cap_offset),
        .sign_ext (cap_signed),
        .data     (load_data)
    );

    assign merged_word = merge_lane(mem_data_i, cap_wdata, cap_size, cap_offset);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        stall_o      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                stall_o     = req_valid_i;
                if (req_valid_i) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (req_write_i && (req_size_eff == SZ_WORD)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                mem_read_o = 1'b1;
                stall_o    = 1'b1;
                if (lat_cnt == '0) begin
                    state_next = cap_write ? WR : RESP;
                end
            end
            WR: begin
                mem_write_o = 1'b1;
                stall_o     = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts down the remaining read cycles; zero marks the sampling cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lat_cnt <= '0;
        end else if (accept) begin
            lat_cnt <= LAT_LAST;
        end else if ((state == RD) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cap_write  <= 1'b0;
            cap_signed <= 1'b0;
            cap_size   <= 2'b00;
            cap_offset <= 2'b00;
            cap_wdata  <= '0;
        end else if (accept) begin
            cap_write  <= req_write_i;
            cap_signed <= req_signed_i;
            cap_size   <= req_size_eff;
            cap_offset <= req_addr_i[1:0];
            cap_wdata  <= req_wdata_i;
        end
    end

    // Memory-side address/data only change when a real access is launched,
    // so they hold their last values across IDLE and RESP.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept && !misaligned) begin
            mem_addr <= {req_addr_i[ADDR_W-1:2], 2'b00};
            if (req_write_i && (req_size_eff == SZ_WORD)) begin
                mem_wdata <= req_wdata_i;
            end
        end else if (rd_done && cap_write) begin
            mem_wdata <= merged_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            resp_rdata <= '0;
        end else if (accept) begin
            resp_rdata <= '0;
        end else if (rd_done && !cap_write) begin
            resp_rdata <= load_data;
        end
    end

    assign mem_addr_o   = mem_addr;
    assign mem_wdata_o  = mem_wdata;
    assign resp_rdata_o = (state == RESP) ? resp_rdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: randomized loads/stores against a
// word-array reference model, plus directed reset, alignment and handshake cases.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int LAT    = 3;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              reqValid = 1'b0;
    logic              reqReady;
    logic              reqWrite = 1'b0;
    logic [1:0]        reqSize = 2'b00;
    logic              reqSigned = 1'b0;
    logic [ADDR_W-1:0] reqAddr = '0;
    logic [31:0]       reqWdata = '0;
    logic              respValid;
    logic [31:0]       respRdata;
    logic              respErr;
    logic              stall;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic              memWrite;
    logic              memRead;
    logic [31:0]       memData;

    int errCount   = 0;
    int checkCount = 0;

    logic [31:0] memArr [64];
    logic [31:0] refMem [64];
    logic [31:0] lastRdata;
    logic        lastErr;

    always #5 clk = ~clk;

    mem_access_unit #(
        .MEM_LATENCY (LAT),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_write_i  (reqWrite),
        .req_size_i   (reqSize),
        .req_signed_i (reqSigned),
        .req_addr_i   (reqAddr),
        .req_wdata_i  (reqWdata),
        .resp_valid_o (respValid),
        .resp_rdata_o (respRdata),
        .resp_err_o   (respErr),
        .stall_o      (stall),
        .mem_addr_o   (memAddr),
        .mem_wdata_o  (memWdata),
        .mem_write_o  (memWrite),
        .mem_read_o   (memRead),
        .mem_data_i   (memData)
    );

    assign memData = memArr[memAddr[7:2]];

    always @(posedge clk) begin
        if (memWrite) memArr[memAddr[7:2]] <= memWdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("strobe_excl", {31'b0, memRead & memWrite}, 32'd0);
    end

    // Transaction-level reference: latency, strobe counts, response and memory effect.
    task automatic refModel(input logic write, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output int nRd, output int nWr, output logic err,
                            output logic [31:0] rdata, output logic [31:0] wword);
        int sz;
        int off;
        int idx;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] lane;
        sz  = (size == 2'b11) ? 2 : int'(size);
        off = int'(addr[1:0]);
        idx = int'(addr[7:2]);
        lat = 0; nRd = 0; nWr = 0; err = 1'b0; rdata = 0; wword = 0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if ((sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0)) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`endif
        w = refMem[idx];
        if (!write) begin
            nRd = LAT;
            lat = LAT + 1;
            if (sz == 0) begin
                lane = (w >> (8 * off)) & 32'hFF;
                if (sgn && lane[7]) lane = lane | 32'hFFFF_FF00;
            end else if (sz == 1) begin
                lane = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (sgn && lane[15]) lane = lane | 32'hFFFF_0000;
            end else begin
                lane = w;
            end
            rdata = lane;
        end else if (sz == 2) begin
            nWr = 1;
            lat = 2;
            wword = wdata;
            refMem[idx] = wdata;
        end else begin
            nRd = LAT;
            nWr = 1;
            lat = LAT + 2;
            if (sz == 0) begin
                mask  = 32'hFF << (8 * off);
                wword = (w & ~mask) | ((wdata & 32'hFF) << (8 * off));
            end else begin
                mask  = 32'hFFFF << (16 * (off / 2));
                wword = (w & ~mask) | ((wdata & 32'hFFFF) << (16 * (off / 2)));
            end
            refMem[idx] = wword;
        end
    endtask

    task automatic applyStimulus(input logic write, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int expLat, expRd, expWr;
        logic expErr;
        logic [31:0] expData, expWord;
        int rdSeen, wrSeen;
        bit done;
        logic [31:0] wrData;
        refModel(write, size, sgn, addr, wdata, expLat, expRd, expWr, expErr, expData, expWord);
        @(negedge clk);
        reqValid = 1'b1; reqWrite = write; reqSize = size; reqSigned = sgn;
        reqAddr = addr; reqWdata = wdata;
        #1;
        checkOutput("ready_idle", {31'b0, reqReady}, 32'd1);
        checkOutput("stall_accept", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqWrite = 1'($urandom); reqSize = 2'($urandom); reqSigned = 1'($urandom);
        reqAddr = $urandom; reqWdata = $urandom;
        rdSeen = 0; wrSeen = 0; done = 0; wrData = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (memRead) begin
                rdSeen++;
                checkOutput("rd_addr", memAddr, {addr[31:2], 2'b00});
            end
            if (memWrite) begin
                wrSeen++;
                wrData = memWdata;
                checkOutput("wr_addr", memAddr, {addr[31:2], 2'b00});
            end
            if (respValid) begin
                done = 1;
                lastRdata = respRdata;
                lastErr   = respErr;
                checkOutput("latency", cyc, expLat);
                checkOutput("resp_err", {31'b0, respErr}, {31'b0, expErr});
                checkOutput("resp_rdata", respRdata, expData);
                checkOutput("rd_cycles", rdSeen, expRd);
                checkOutput("wr_cycles", wrSeen, expWr);
                checkOutput("ready_resp", {31'b0, reqReady}, 32'd0);
                checkOutput("stall_resp", {31'b0, stall}, 32'd0);
                if (expWr != 0) checkOutput("wr_data", wrData, expWord);
            end else begin
                checkOutput("stall_busy", {31'b0, stall}, 32'd1);
                @(posedge clk);
                #1;
            end
        end
        if (!done) checkOutput("resp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int respCount;
        for (int i = 0; i < 64; i++) refMem[i] = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'b0, reqReady}, 32'd1);
        checkOutput("rst_valid", {31'b0, respValid}, 32'd0);
        checkOutput("rst_rdata", respRdata, 32'd0);
        checkOutput("rst_err", {31'b0, respErr}, 32'd0);
        checkOutput("rst_strobes", {30'b0, memRead, memWrite}, 32'd0);
        checkOutput("rst_addr", memAddr, 32'd0);
        checkOutput("rst_wdata", memWdata, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        rstN = 1'b1;

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        checkOutput("word_load_const", lastRdata, 32'hDEAD_BEEF);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h04, 32'h1234_80FF);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h05, 32'h0);
        checkOutput("sbyte_const", lastRdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h05, 32'h0);
        checkOutput("ubyte_const", lastRdata, 32'h0000_0080);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0C, 32'h1122_3344);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_ABCD);
        checkOutput("rmw_mem_const", memArr[3], 32'hABCD_3344);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        checkOutput("misalign_err", {31'b0, lastErr}, 32'd1);
`else
        checkOutput("misalign_noerr", {31'b0, lastErr}, 32'd0);
`endif

        // Abort a load on its second read cycle.
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0; reqAddr = 32'h10;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_rd_before", {31'b0, memRead}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("abort_strobes", {30'b0, memRead, memWrite}, 32'd0);
        checkOutput("abort_ready", {31'b0, reqReady}, 32'd1);
        checkOutput("abort_addr", memAddr, 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort_no_resp", {31'b0, respValid}, 32'd0);
        end
        rstN = 1'b1;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Continuous request: stall drops only on response cycles.
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0; reqAddr = 32'h20;
        respCount = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checkOutput("bb_stall", {31'b0, stall}, {31'b0, !respValid});
            if (respValid) begin
                respCount++;
                checkOutput("bb_ready", {31'b0, reqReady}, 32'd0);
                checkOutput("bb_data", respRdata, refMem[8]);
            end
        end
        reqValid = 1'b0;
        checkOutput("bb_count", respCount, 60 / (LAT + 2));

        for (int n = 0; n < 150; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 39)), $urandom);
        end

        for (int i = 0; i < 10; i++) checkOutput("final_mem", memArr[i], refMem[i]);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator for the MEM stage. It sits between the pipeline and the word-wide, byte-addressed, little-endian data memory. It accepts one byte, half or word request from the pipeline and drives the memory's address, write-data and read/write strobes. Sub-word stores are done as read-modify-write; load data is returned zero- or sign-extended. The pipeline is stalled while an access is in flight.

Parameters:
MEM_LATENCY, 1, cycles mem_read_o is held before mem_data_i is sampled; legal range 1..15
ADDR_W, 32, address width

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  1  pipeline request valid
req_ready_o  out  1  unit can accept a request
req_write_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_signed_i  in  1  sign-extend load result
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  32  store data, right-aligned
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  32  extended load data; 0 for stores
resp_err_o  out  1  misaligned access (see Optional Feature)
stall_o  out  1  pipeline hold
mem_addr_o  out  ADDR_W  word-aligned address to data memory ({addr[ADDR_W-1:2],2'b00})
mem_wdata_o  out  32  write data to data memory
mem_write_o  out  1  memory write strobe
mem_read_o  out  1  memory read strobe
mem_data_i  in  32  memory read data

Behaviour:
- Reset is asynchronous. It forces state IDLE, the latency counter to 0, and all captured request registers to 0. Outputs under reset: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mem_read_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
- Reset mid-access abandons the access immediately. The strobes drop in the same cycle. No response is issued.
- States are IDLE, RD, WR, RESP.
- IDLE: req_ready_o=1. On req_valid_i the request (write, size, signed, addr, wdata) is captured. Next state:
  - RESP if the access is misaligned and the check is enabled;
  - WR if it is a word store;
  - RD otherwise (all loads and sub-word stores).
- RD: mem_read_o=1 for exactly MEM_LATENCY cycles. mem_data_i is sampled on the final RD cycle's clock edge.
  - A load then goes to RESP.
  - A sub-word store merges req_wdata_i into the read word at the lane selected by addr[1:0], then goes to WR.
- WR: mem_write_o=1 for exactly one cycle with mem_wdata_o = the full word (direct or merged), then RESP.
- RESP: resp_valid_o=1 for one cycle, then IDLE. req_ready_o=0 in RESP, so there are no back-to-back accepts.
- Only one memory strobe is ever asserted at a time. mem_read_o and mem_write_o are never high together.
- mem_addr_o and mem_wdata_o hold their last values outside RD/WR.
- Lane mapping: byte k occupies bits [8k+7:8k]. Half-word at addr[1]=h occupies bits [16h+15:16h].
- Load extension: bit 7 (byte) or bit 15 (half) is replicated when req_signed_i=1; otherwise the upper bits are zero-filled.
- stall_o = (IDLE && req_valid_i) || RD || WR. stall_o is 0 in RESP, so the pipeline advances on the response cycle.
- Latency, counted from the accept edge to resp_valid_o:
  - word/sub-word load: MEM_LATENCY+1 cycles;
  - word store: 2 cycles;
  - sub-word store: MEM_LATENCY+2 cycles;
  - error: 1 cycle.
- req_* inputs are ignored outside IDLE.

Optional Feature:
MEM_ACCESS_ALIGN_CHECK_EN
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=0, goes IDLE->RESP. It responds with resp_err_o=1 and resp_rdata_o=0, and no memory strobe is asserted.
- Undefined: resp_err_o is tied 0. Low address bits below the access size are ignored: word uses lane 0; half uses addr[1].

Decomposition:
- Shared package mem_access_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum (IDLE, RD, WR, RESP);
  - a function for lane merge.
- One natural sub-module: load_align_ext. It is combinational and performs lane select plus sign/zero extension, so it can be unit-tested separately.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x08, then load word @0x08 with MEM_LATENCY=1.
  - Store: mem_write_o pulses once with addr 0x08; resp at +2.
  - Load: resp_rdata_o=0xDEADBEEF at +2.
- Signed byte load: word @0x04 = 0x1234_80FF; load byte @0x05.
  - signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Sub-word store RMW: word @0x0C = 0x11223344; store half 0xABCD @0x0E.
  - Observe mem_read_o for MEM_LATENCY cycles, then mem_write_o with 0xABCD3344; resp at MEM_LATENCY+2.
- Misalign with the macro defined: load word @0x06.
  - resp_err_o=1 at +1; mem_read_o and mem_write_o stay 0 throughout.
- Reset mid-access: assert rst_n_i low on the second RD cycle with MEM_LATENCY=3.
  - Strobes are 0 immediately and no resp_valid_o; after release, req_ready_o=1 and the next request completes normally.
- Stall/handshake: hold req_valid_i high continuously.
  - stall_o is high except in RESP cycles; requests are accepted only in IDLE; the strobe-exclusivity assertion is never violated.
